// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: MEM-stage FSM encoding, EX/MEM control bundle and bubble constant.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACCESS    = 2'd1,
        ALIGN_ERR = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
    } mem_ctrl_t;

    localparam mem_ctrl_t BUBBLE_CTRL = '0;

    function automatic logic is_mem_op(input mem_ctrl_t c);
        return c.mem_read | c.mem_write;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: request/acknowledge bus between the MEM stage (master) and data memory (slave).
interface mem_stage_if #(
    parameter int DATA_W = 32
);
    logic              DMem_Req;
    logic              DMem_We;
    logic [DATA_W-1:0] DMem_Addr;
    logic [DATA_W-1:0] DMem_WData;
    logic [DATA_W-1:0] DMem_RData;
    logic              DMem_Ack;

    modport master (
        output DMem_Req, DMem_We, DMem_Addr, DMem_WData,
        input  DMem_RData, DMem_Ack
    );

    modport slave (
        input  DMem_Req, DMem_We, DMem_Addr, DMem_WData,
        output DMem_RData, DMem_Ack
    );
endinterface

// File: rtl/mem_stage_dmem_handshake.sv
// mem_stage_dmem_handshake: MEM-stage FSM generating Req/We/Stall for the data-memory access.
// With MEM_ALIGN_CHECK_EN defined, misaligned accesses are diverted to ALIGN_ERR.
module mem_stage_dmem_handshake
    import mem_stage_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic next_mem_op,
`ifdef MEM_ALIGN_CHECK_EN
    input  logic next_misaligned,
`endif
    input  logic cur_mem_read,
    input  logic cur_mem_write,
    input  logic ack,
    output logic req,
    output logic we,
    output logic stall,
    output logic align_err
);

    mem_state_e state, state_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The state follows the op being loaded into EX/MEM, so it only moves on non-stalled edges.
    always_comb begin
        state_next = state;
        if (!stall) begin
            if (!next_mem_op) begin
                state_next = IDLE;
            end
`ifdef MEM_ALIGN_CHECK_EN
            else if (next_misaligned) begin
                state_next = ALIGN_ERR;
            end
`endif
            else begin
                state_next = ACCESS;
            end
        end
    end

    always_comb begin
        req       = 1'b0;
        we        = 1'b0;
        stall     = 1'b0;
        align_err = 1'b0;
        unique case (state)
            ACCESS: begin
                req   = cur_mem_read | cur_mem_write;
                we    = cur_mem_write;
                stall = ~ack;
            end
            ALIGN_ERR: align_err = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: EX/MEM and MEM/WB pipeline registers around the data-memory req/ack handshake.
// Optional MEM_ALIGN_CHECK_EN adds misaligned-access trapping and the AlignErr output.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [DATA_W-1:0] EX_ALUOut,
    input  logic [DATA_W-1:0] EX_StoreData,
    input  logic [REG_W-1:0]  EX_DestReg,
    input  logic              EX_RegWrite,
    input  logic              EX_MemRead,
    input  logic              EX_MemWrite,
    input  logic              EX_MemToReg,
    input  logic              ForC,
    input  logic              Flush,
    output logic [DATA_W-1:0] EXMEM_ALUOut,
    output logic [REG_W-1:0]  EXMEM_RegRd,
    output logic              EXMEM_RegWrite,
    output logic              EXMEM_MemWrite,
    mem_stage_if.master       dmem,
    output logic [DATA_W-1:0] MEMWB_WriteData,
    output logic [REG_W-1:0]  MEMWB_RegRd,
    output logic              MEMWB_RegWrite,
    output logic              MEMWB_MemToReg,
    output logic              Stall
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic              AlignErr
`endif
);

    mem_ctrl_t         ex_ctrl;
    mem_ctrl_t         capture_ctrl;
    mem_ctrl_t         exmem_ctrl;
    logic [DATA_W-1:0] exmem_alu;
    logic [DATA_W-1:0] exmem_store;
    logic [REG_W-1:0]  exmem_rd;
    logic              stall;
    logic              align_err;
    logic              wb_mem_to_reg;

    assign ex_ctrl = '{
        reg_write:  EX_RegWrite,
        mem_read:   EX_MemRead,
        mem_write:  EX_MemWrite,
        mem_to_reg: EX_MemToReg
    };
    assign capture_ctrl = Flush ? BUBBLE_CTRL : ex_ctrl;

`ifdef MEM_ALIGN_CHECK_EN
    logic misaligned;
    assign misaligned = |EX_ALUOut[1:0];
    assign AlignErr   = align_err;
`endif

    mem_stage_dmem_handshake u_handshake (
        .clk             (Clock),
        .rst_n           (Reset),
        .next_mem_op     (is_mem_op(capture_ctrl)),
`ifdef MEM_ALIGN_CHECK_EN
        .next_misaligned (misaligned),
`endif
        .cur_mem_read    (exmem_ctrl.mem_read),
        .cur_mem_write   (exmem_ctrl.mem_write),
        .ack             (dmem.DMem_Ack),
        .req             (dmem.DMem_Req),
        .we              (dmem.DMem_We),
        .stall           (stall),
        .align_err       (align_err)
    );

    // EX/MEM: frozen while stalled, so a Flush held during the stall cannot drop the pending op.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            exmem_ctrl  <= BUBBLE_CTRL;
            exmem_alu   <= '0;
            exmem_store <= '0;
            exmem_rd    <= '0;
        end else if (!stall) begin
            exmem_ctrl <= capture_ctrl;
            if (Flush) begin
                exmem_alu   <= '0;
                exmem_store <= '0;
                exmem_rd    <= '0;
            end else begin
                exmem_alu   <= EX_ALUOut;
                exmem_store <= ForC ? MEMWB_WriteData : EX_StoreData;
                exmem_rd    <= EX_DestReg;
            end
        end
    end

    assign wb_mem_to_reg = exmem_ctrl.mem_to_reg & ~align_err;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            MEMWB_WriteData <= '0;
            MEMWB_RegRd     <= '0;
            MEMWB_RegWrite  <= 1'b0;
            MEMWB_MemToReg  <= 1'b0;
        end else if (stall) begin
            MEMWB_RegWrite <= 1'b0;
            MEMWB_MemToReg <= 1'b0;
        end else begin
            MEMWB_RegRd     <= exmem_rd;
            MEMWB_RegWrite  <= exmem_ctrl.reg_write & ~align_err;
            MEMWB_MemToReg  <= wb_mem_to_reg;
            MEMWB_WriteData <= wb_mem_to_reg ? dmem.DMem_RData : exmem_alu;
        end
    end

    assign EXMEM_ALUOut    = exmem_alu;
    assign EXMEM_RegRd     = exmem_rd;
    assign EXMEM_RegWrite  = exmem_ctrl.reg_write;
    assign EXMEM_MemWrite  = exmem_ctrl.mem_write;
    assign dmem.DMem_Addr  = exmem_alu;
    assign dmem.DMem_WData = exmem_store;
    assign Stall           = stall;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vector table, hand-written corner sequences and a randomized run
// against a transaction-level model of the MEM stage and a word-addressed data memory.
module tb_mem_stage;
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] store;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        mtr;
        logic        forc;
        logic        flush;
    } op_t;

    typedef struct packed {
        op_t         op;
        logic [3:0]  waits;
        logic [31:0] rdata;
        logic        flush_in_stall;
        logic        exp_req;
        logic        exp_we;
        logic [31:0] exp_wdata;
        logic [31:0] exp_wd;
        logic [4:0]  exp_rd;
        logic        exp_rw;
        logic        exp_mtr;
        logic [3:0]  exp_stalls;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ex_alu, ex_store;
    logic [4:0]  ex_rd;
    logic        ex_rw, ex_mr, ex_mw, ex_mtr, forc, flush;
    logic [31:0] exmem_alu;
    logic [4:0]  exmem_rd;
    logic        exmem_rw, exmem_mw;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_rw, wb_mtr, stall;
`ifdef MEM_ALIGN_CHECK_EN
    logic        align_err;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    vec_t        vecs [10];
    logic [31:0] mem_words [logic [31:0]];

    mem_stage_if #(.DATA_W(DATA_W)) dmem ();

    mem_stage #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
        .Clock           (clk),
        .Reset           (rst_n),
        .EX_ALUOut       (ex_alu),
        .EX_StoreData    (ex_store),
        .EX_DestReg      (ex_rd),
        .EX_RegWrite     (ex_rw),
        .EX_MemRead      (ex_mr),
        .EX_MemWrite     (ex_mw),
        .EX_MemToReg     (ex_mtr),
        .ForC            (forc),
        .Flush           (flush),
        .EXMEM_ALUOut    (exmem_alu),
        .EXMEM_RegRd     (exmem_rd),
        .EXMEM_RegWrite  (exmem_rw),
        .EXMEM_MemWrite  (exmem_mw),
        .dmem            (dmem),
        .MEMWB_WriteData (wb_data),
        .MEMWB_RegRd     (wb_rd),
        .MEMWB_RegWrite  (wb_rw),
        .MEMWB_MemToReg  (wb_mtr),
        .Stall           (stall)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .AlignErr        (align_err)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic op_t alu_op(input logic [31:0] alu, input logic [4:0] rd);
        op_t o = '0;
        o.alu = alu; o.rd = rd; o.rw = 1'b1;
        return o;
    endfunction

    function automatic op_t lw_op(input logic [31:0] addr, input logic [4:0] rd);
        op_t o = '0;
        o.alu = addr; o.rd = rd; o.rw = 1'b1; o.mr = 1'b1; o.mtr = 1'b1;
        return o;
    endfunction

    function automatic op_t sw_op(input logic [31:0] addr, input logic [31:0] data, input logic fc);
        op_t o = '0;
        o.alu = addr; o.store = data; o.mw = 1'b1; o.forc = fc;
        return o;
    endfunction

    function automatic op_t with_flush(input op_t o);
        op_t r = o;
        r.flush = 1'b1;
        return r;
    endfunction

    function automatic vec_t mkv(input op_t op, input logic [3:0] waits, input logic [31:0] rdata,
                                 input logic fis, input logic req, input logic we,
                                 input logic [31:0] wdata, input logic [31:0] wd,
                                 input logic [4:0] rd, input logic rw, input logic mtr,
                                 input logic [3:0] stalls);
        vec_t v;
        v.op = op; v.waits = waits; v.rdata = rdata; v.flush_in_stall = fis;
        v.exp_req = req; v.exp_we = we; v.exp_wdata = wdata;
        v.exp_wd = wd; v.exp_rd = rd; v.exp_rw = rw; v.exp_mtr = mtr; v.exp_stalls = stalls;
        return v;
    endfunction

    task automatic drive_op(input op_t o);
        ex_alu = o.alu; ex_store = o.store; ex_rd = o.rd;
        ex_rw = o.rw; ex_mr = o.mr; ex_mw = o.mw; ex_mtr = o.mtr;
        forc = o.forc; flush = o.flush;
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_words.exists(a)) return mem_words[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic op_t rand_op();
        op_t         o;
        int unsigned k = $urandom_range(0, 9);
        logic [31:0] addr = 32'h100 + 32'($urandom_range(0, 15)) * 4;
        if (k < 4)      o = alu_op($urandom, 5'($urandom));
        else if (k < 7) o = lw_op(addr, 5'($urandom));
        else if (k < 9) o = sw_op(addr, $urandom, 1'b0);
        else            o = '0;
        o.store = $urandom;
        o.forc  = ($urandom_range(0, 3) == 0);
        o.flush = ($urandom_range(0, 7) == 0);
        return o;
    endfunction

    task automatic run_vec(input vec_t v, input int unsigned idx);
        int unsigned waited  = 0;
        int unsigned stalls  = 0;
        logic        retired = 1'b0;
        logic        is_mem  = (v.op.mr | v.op.mw) & ~v.op.flush;
        logic        ack;
        op_t         idle_op = '0;
        idle_op.flush = v.flush_in_stall;
        @(negedge clk);
        drive_op(v.op);
        dmem.DMem_Ack = 1'b0;
        @(posedge clk);
        for (int unsigned c = 0; c < 20 && !retired; c++) begin
            @(negedge clk);
            drive_op(idle_op);
            ack = is_mem && (waited == 32'(v.waits));
            dmem.DMem_Ack   = ack;
            dmem.DMem_RData = ack ? v.rdata : $urandom;
            #1;
            if (c == 0) begin
                chk($sformatf("v%0d req", idx), dmem.DMem_Req, v.exp_req);
                chk($sformatf("v%0d addr", idx), dmem.DMem_Addr, v.op.flush ? 32'h0 : v.op.alu);
                chk($sformatf("v%0d exmem_rd", idx), exmem_rd, v.op.flush ? 5'd0 : v.op.rd);
                chk($sformatf("v%0d exmem_rw", idx), exmem_rw, v.op.rw & ~v.op.flush);
                chk($sformatf("v%0d exmem_mw", idx), exmem_mw, v.op.mw & ~v.op.flush);
                if (v.exp_req) begin
                    chk($sformatf("v%0d we", idx), dmem.DMem_We, v.exp_we);
                    if (v.exp_we) chk($sformatf("v%0d wdata", idx), dmem.DMem_WData, v.exp_wdata);
                end
            end
            if (stall) stalls++;
            @(posedge clk);
            #1;
            if (!is_mem || ack) retired = 1'b1;
            else begin
                waited++;
                chk($sformatf("v%0d wb_rw in stall", idx), wb_rw, 1'b0);
            end
        end
        dmem.DMem_Ack = 1'b0;
        chk($sformatf("v%0d retired", idx), retired, 1'b1);
        chk($sformatf("v%0d stall cycles", idx), stalls, v.exp_stalls);
        chk($sformatf("v%0d wb_data", idx), wb_data, v.exp_wd);
        chk($sformatf("v%0d wb_rd", idx), wb_rd, v.exp_rd);
        chk($sformatf("v%0d wb_rw", idx), wb_rw, v.exp_rw);
        chk($sformatf("v%0d wb_mtr", idx), wb_mtr, v.exp_mtr);
    endtask

    task automatic run_random(input int unsigned cycles);
        op_t         m_ex = '0;
        op_t         nxt, cap;
        logic [31:0] m_wd = '0;
        logic [31:0] prev_wd, loaded;
        logic [4:0]  m_rd = '0;
        logic        m_rw = 1'b0, m_mtr = 1'b0;
        logic        busy, ack, exp_stall;
        int unsigned wait_target = 0, waited = 0;
        for (int unsigned i = 0; i < cycles; i++) begin
            @(negedge clk);
            nxt = rand_op();
            drive_op(nxt);
            busy   = m_ex.mr | m_ex.mw;
            ack    = busy ? (waited >= wait_target) : ($urandom_range(0, 3) == 0);
            loaded = mem_rd(m_ex.alu);
            dmem.DMem_Ack   = ack;
            dmem.DMem_RData = (busy && ack) ? loaded : $urandom;
            #1;
            exp_stall = busy & ~ack;
            chk("rnd req", dmem.DMem_Req, busy);
            chk("rnd we", dmem.DMem_We, busy & m_ex.mw);
            chk("rnd addr", dmem.DMem_Addr, m_ex.alu);
            chk("rnd wdata", dmem.DMem_WData, m_ex.store);
            chk("rnd stall", stall, exp_stall);
            chk("rnd exmem_rd", exmem_rd, m_ex.rd);
            chk("rnd exmem_rw", exmem_rw, m_ex.rw);
            chk("rnd exmem_mw", exmem_mw, m_ex.mw);
            chk("rnd wb_data", wb_data, m_wd);
            chk("rnd wb_rd", wb_rd, m_rd);
            chk("rnd wb_rw", wb_rw, m_rw);
            chk("rnd wb_mtr", wb_mtr, m_mtr);
            @(posedge clk);
            if (exp_stall) begin
                m_rw = 1'b0;
                m_mtr = 1'b0;
                waited++;
            end else begin
                prev_wd = m_wd;
                if (busy && m_ex.mw) mem_words[m_ex.alu] = m_ex.store;
                m_rd  = m_ex.rd;
                m_rw  = m_ex.rw;
                m_mtr = m_ex.mtr;
                m_wd  = m_ex.mtr ? loaded : m_ex.alu;
                cap = nxt;
                if (nxt.flush) cap = '0;
                else if (nxt.forc) cap.store = prev_wd;
                cap.forc = 1'b0;
                cap.flush = 1'b0;
                m_ex = cap;
                waited = 0;
                wait_target = $urandom_range(0, 3);
            end
        end
        dmem.DMem_Ack = 1'b0;
    endtask

    initial begin
        vecs[0] = mkv(alu_op(32'h10, 5'd8), 0, 0, 0, 0, 0, 0, 32'h10, 5'd8, 1, 0, 0);
        vecs[1] = mkv(lw_op(32'h100, 5'd9), 3, 32'hDEADBEEF, 0, 1, 0, 0, 32'hDEADBEEF, 5'd9, 1, 1, 3);
        vecs[2] = mkv(alu_op(32'h1234, 5'd10), 0, 0, 0, 0, 0, 0, 32'h1234, 5'd10, 1, 0, 0);
        vecs[3] = mkv(sw_op(32'h200, 32'h9999, 1'b1), 0, 0, 0, 1, 1, 32'h1234, 32'h200, 5'd0, 0, 0, 0);
        vecs[4] = mkv(sw_op(32'h204, 32'hCAFE, 1'b0), 1, 0, 0, 1, 1, 32'hCAFE, 32'h204, 5'd0, 0, 0, 1);
        vecs[5] = mkv(with_flush(alu_op(32'h55, 5'd8)), 0, 0, 0, 0, 0, 0, 32'h0, 5'd0, 0, 0, 0);
        vecs[6] = mkv(alu_op(32'hABCD, 5'd0), 0, 0, 0, 0, 0, 0, 32'hABCD, 5'd0, 1, 0, 0);
        vecs[7] = mkv(lw_op(32'h300, 5'd4), 0, 32'h0BADF00D, 0, 1, 0, 0, 32'h0BADF00D, 5'd4, 1, 1, 0);
        vecs[8] = mkv(with_flush(lw_op(32'h304, 5'd6)), 0, 0, 0, 0, 0, 0, 32'h0, 5'd0, 0, 0, 0);
        vecs[9] = mkv(lw_op(32'h100, 5'd11), 2, 32'h11112222, 1, 1, 0, 0, 32'h11112222, 5'd11, 1, 1, 2);

        rst_n = 1'b0;
        drive_op('0);
        dmem.DMem_Ack   = 1'b1;
        dmem.DMem_RData = 32'hFFFF_FFFF;
        #1;
        chk("reset req", dmem.DMem_Req, 1'b0);
        chk("reset we", dmem.DMem_We, 1'b0);
        chk("reset stall", stall, 1'b0);
        chk("reset exmem_alu", exmem_alu, 32'h0);
        chk("reset wb_data", wb_data, 32'h0);
        chk("reset wb_rw", wb_rw, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dmem.DMem_Ack = 1'b0;

        for (int unsigned i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Back-to-back loads with zero-wait acks.
        @(negedge clk);
        drive_op(lw_op(32'h104, 5'd5));
        @(posedge clk);
        @(negedge clk);
        drive_op(lw_op(32'h108, 5'd6));
        dmem.DMem_Ack = 1'b1;
        dmem.DMem_RData = 32'hAAAA_0001;
        #1;
        chk("b2b req1", dmem.DMem_Req, 1'b1);
        chk("b2b stall1", stall, 1'b0);
        chk("b2b addr1", dmem.DMem_Addr, 32'h104);
        @(posedge clk);
        #1;
        chk("b2b wb1 data", wb_data, 32'hAAAA_0001);
        chk("b2b wb1 rd", wb_rd, 5'd5);
        chk("b2b wb1 mtr", wb_mtr, 1'b1);
        @(negedge clk);
        drive_op('0);
        dmem.DMem_RData = 32'hBBBB_0002;
        #1;
        chk("b2b req2", dmem.DMem_Req, 1'b1);
        chk("b2b stall2", stall, 1'b0);
        chk("b2b addr2", dmem.DMem_Addr, 32'h108);
        @(posedge clk);
        #1;
        chk("b2b wb2 data", wb_data, 32'hBBBB_0002);
        chk("b2b wb2 rd", wb_rd, 5'd6);
        @(negedge clk);
        dmem.DMem_Ack = 1'b0;
        #1;
        chk("b2b req idle", dmem.DMem_Req, 1'b0);

        // Reset asserted while a load waits for its ack; a late ack must be ignored.
        @(negedge clk);
        drive_op(alu_op(32'h77, 5'd3));
        @(posedge clk);
        @(negedge clk);
        drive_op(lw_op(32'h140, 5'd7));
        @(posedge clk);
        @(negedge clk);
        drive_op('0);
        #1;
        chk("rst pre stall", stall, 1'b1);
        chk("rst pre wb_data", wb_data, 32'h77);
        chk("rst pre addr", dmem.DMem_Addr, 32'h140);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst req", dmem.DMem_Req, 1'b0);
        chk("rst stall", stall, 1'b0);
        chk("rst exmem_alu", exmem_alu, 32'h0);
        chk("rst exmem_rd", exmem_rd, 5'd0);
        chk("rst wb_data", wb_data, 32'h0);
        chk("rst wb_rd", wb_rd, 5'd0);
        dmem.DMem_Ack = 1'b1;
        dmem.DMem_RData = 32'h5555_AAAA;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst late ack req", dmem.DMem_Req, 1'b0);
        chk("rst late ack stall", stall, 1'b0);
        @(posedge clk);
        #1;
        chk("rst late ack wb_rw", wb_rw, 1'b0);
        chk("rst late ack wb_data", wb_data, 32'h0);
        dmem.DMem_Ack = 1'b0;

`ifdef MEM_ALIGN_CHECK_EN
        @(negedge clk);
        drive_op(lw_op(32'h102, 5'd9));
        @(posedge clk);
        @(negedge clk);
        drive_op('0);
        dmem.DMem_Ack = 1'b1;
        #1;
        chk("align err", align_err, 1'b1);
        chk("align req", dmem.DMem_Req, 1'b0);
        chk("align stall", stall, 1'b0);
        @(posedge clk);
        #1;
        chk("align wb_rw", wb_rw, 1'b0);
        @(negedge clk);
        dmem.DMem_Ack = 1'b0;
        #1;
        chk("align err clears", align_err, 1'b0);
`endif

        @(negedge clk);
        drive_op('0);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        run_random(2000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
